// File: rtl/spi_flash_read_sequencer.sv
// spi_flash_read_sequencer: APB master that walks a SPI controller through a
// flash READ (0x03) sequence and streams the returned payload bytes.
module spi_flash_read_sequencer #(
  parameter logic [31:0] BASEADDR   = 32'h90034000,
  parameter logic [7:0]  OFS_CSMODE = 8'h18,
  parameter logic [7:0]  OFS_TXDATA = 8'h48,
  parameter logic [7:0]  OFS_RXDATA = 8'h4C,
  parameter int          LEN_W      = 16,
  parameter int          POLL_MAX   = 1023
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [23:0]      req_addr,
  input  logic [LEN_W-1:0] req_len,
  output logic             rd_valid,
  input  logic             rd_ready,
  output logic [7:0]       rd_data,
  output logic             done,
  output logic             error,
  output logic             rpsel,
  output logic             rpenable,
  output logic             rpwrite,
  output logic [31:0]      rpaddr,
  output logic [31:0]      rpwdata,
  input  logic [31:0]      rprdata,
  input  logic             rpready,
  input  logic             rpslverr
);
  localparam int PW = $clog2(POLL_MAX + 1);
  localparam int IW = LEN_W + 1;

  typedef enum logic [3:0] {
    S_IDLE, S_CS_HOLD, S_TX_POLL, S_TX_WR, S_RX_POLL,
    S_OUT, S_NEXT, S_CS_REL, S_DONE
  } state_t;

  typedef enum logic [1:0] {PH_GAP, PH_SETUP, PH_ACCESS} phase_t;

  state_t state, state_n;
  phase_t ph, ph_n;

  logic [23:0]   addr_q;
  logic [IW-1:0] total_q;
  logic [IW-1:0] idx_q, idx_n;
  logic [PW-1:0] poll_q, poll_n;
  logic          err_q, err_n;
  logic [7:0]    rx_q, rx_n;
  logic          take, apb_st, wr_st, xfer;
  logic          busy, poll_hit, fail;
  logic [7:0]    ofs, tx_byte;
  logic          unused_rdata;

  assign unused_rdata = ^rprdata[30:8];
  assign take     = req_valid && req_ready;
  assign apb_st   = state inside {S_CS_HOLD, S_TX_POLL, S_TX_WR,
                                  S_RX_POLL, S_CS_REL};
  assign wr_st    = state inside {S_CS_HOLD, S_TX_WR, S_CS_REL};
  assign xfer     = apb_st && (ph == PH_ACCESS) && rpready;
  assign busy     = rprdata[31];
  assign poll_hit = (poll_q == PW'(POLL_MAX - 1));
  // a poll fails on slave error or on the last allowed busy answer
  assign fail     = rpslverr || (busy && poll_hit);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
      ph    <= PH_GAP;
    end else begin
      state <= state_n;
      ph    <= ph_n;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_q  <= '0;
      total_q <= '0;
      idx_q   <= '0;
      poll_q  <= '0;
      err_q   <= 1'b0;
      rx_q    <= '0;
    end else begin
      idx_q  <= idx_n;
      poll_q <= poll_n;
      err_q  <= err_n;
      rx_q   <= rx_n;
      if (take) begin
        addr_q  <= req_addr;
        total_q <= IW'(req_len) + IW'(4);
      end
    end
  end

  always_comb begin
    tx_byte = 8'h00;
    if (idx_q == IW'(0))      tx_byte = 8'h03;
    else if (idx_q == IW'(1)) tx_byte = addr_q[23:16];
    else if (idx_q == IW'(2)) tx_byte = addr_q[15:8];
    else if (idx_q == IW'(3)) tx_byte = addr_q[7:0];
  end

  always_comb begin
    ph_n = ph;
    if (apb_st) begin
      unique case (ph)
        PH_GAP:    ph_n = PH_SETUP;
        PH_SETUP:  ph_n = PH_ACCESS;
        PH_ACCESS: if (rpready) ph_n = PH_GAP;
        default:   ph_n = PH_GAP;
      endcase
    end
  end

  always_comb begin
    state_n = state;
    idx_n   = idx_q;
    poll_n  = poll_q;
    err_n   = err_q;
    rx_n    = rx_q;
    unique case (state)
      S_IDLE: if (take) begin
        state_n = S_CS_HOLD;
        idx_n   = '0;
        poll_n  = '0;
        err_n   = 1'b0;
      end
      S_CS_HOLD, S_TX_WR: if (xfer) begin
        if (rpslverr) begin
          err_n   = 1'b1;
          state_n = S_CS_REL;
        end else begin
          state_n = (state == S_CS_HOLD) ? S_TX_POLL : S_RX_POLL;
        end
      end
      S_TX_POLL, S_RX_POLL: if (xfer) begin
        if (fail) begin
          err_n   = 1'b1;
          poll_n  = '0;
          state_n = S_CS_REL;
        end else if (busy) begin
          poll_n = poll_q + PW'(1);
        end else begin
          poll_n = '0;
          if (state == S_TX_POLL) begin
            state_n = S_TX_WR;
          end else begin
            rx_n    = rprdata[7:0];
            state_n = (idx_q < IW'(4)) ? S_NEXT : S_OUT;
          end
        end
      end
      S_OUT: if (rd_ready) state_n = S_NEXT;
      S_NEXT: begin
        if (idx_q == total_q - IW'(1)) begin
          state_n = S_CS_REL;
        end else begin
          idx_n   = idx_q + IW'(1);
          state_n = S_TX_POLL;
        end
      end
      S_CS_REL: if (xfer) begin
        if (rpslverr) err_n = 1'b1;
        state_n = S_DONE;
      end
      S_DONE:  state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  always_comb begin
    ofs = 8'h00;
    if (state inside {S_CS_HOLD, S_CS_REL})     ofs = OFS_CSMODE;
    else if (state inside {S_TX_POLL, S_TX_WR}) ofs = OFS_TXDATA;
    else if (state == S_RX_POLL)                ofs = OFS_RXDATA;
  end

  always_comb begin
    rpwdata = '0;
    if (rpwrite) begin
      if (state == S_CS_HOLD)  rpwdata = 32'd2;
      else if (state == S_TX_WR) rpwdata = {24'h0, tx_byte};
    end
  end

  assign rpsel     = apb_st && (ph != PH_GAP);
  assign rpenable  = apb_st && (ph == PH_ACCESS);
  assign rpwrite   = rpsel && wr_st;
  assign rpaddr    = rpsel ? (BASEADDR + {24'h0, ofs}) : '0;
  assign req_ready = (state == S_IDLE);
  assign rd_valid  = (state == S_OUT);
  assign rd_data   = rd_valid ? rx_q : '0;
  assign done      = (state == S_DONE);
  assign error     = done && err_q;

endmodule
